// File: rtl/fetch_pc_unit.sv
// fetch_pc_unit: instruction-fetch stage in front of the decoder.
// It owns the PC, issues reads on the SRAM bus it shares with the data-memory
// stage, and presents the fetched instruction together with its PC.
// Taken branches and jumps resolved from the ID-stage operands redirect the PC.
//
// Ports:
//   clk, rst           clock; asynchronous active-low reset
//   stall              hazard-unit stall, holds IF and ID
//   mem_busy           data-memory stage owns the SRAM bus this cycle
//   jumpControl        decoder transfer kind (IDLE/EQZ/NEZ/TEQZ/TNEZ/JUMP/DB)
//   id_pc, id_operandX, id_regT, id_offset   ID-stage operands for resolution
//   imem_req/addr      instruction-memory read request and address
//   imem_rdata/ready   read data, valid when ready (may complete same cycle)
//   instruction, if_pc fetched instruction and its PC to the decoder
//   redirect           one-cycle pulse after a taken transfer is accepted
module fetch_pc_unit #(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter logic [15:0] NOP_INSTR = 16'h0800
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        mem_busy,
  input  logic [2:0]  jumpControl,
  input  logic [15:0] id_pc,
  input  logic [15:0] id_operandX,
  input  logic [15:0] id_regT,
  input  logic [15:0] id_offset,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic [15:0] imem_rdata,
  input  logic        imem_ready,
  output logic [15:0] instruction,
  output logic [15:0] if_pc,
  output logic        redirect
);

  localparam logic [2:0] JC_EQZ  = 3'd1;
  localparam logic [2:0] JC_NEZ  = 3'd2;
  localparam logic [2:0] JC_TEQZ = 3'd3;
  localparam logic [2:0] JC_TNEZ = 3'd4;
  localparam logic [2:0] JC_JUMP = 3'd5;
  localparam logic [2:0] JC_DB   = 3'd6;

  typedef enum logic [1:0] {S_BOOT, S_FETCH, S_DROP} state_t;

  state_t      r_state, w_next_state;
  logic [15:0] r_pc, r_instr, r_if_pc, r_drop_addr;
  logic        r_redirect;
  logic        w_taken, w_accept;
  logic [15:0] w_target;

  // Transfer resolution from the ID-stage operands.
  always_comb begin
    w_taken = 1'b0;
    case (jumpControl)
      JC_EQZ:         w_taken = (id_operandX == 16'd0);
      JC_NEZ:         w_taken = (id_operandX != 16'd0);
      JC_TEQZ:        w_taken = (id_regT == 16'd0);
      JC_TNEZ:        w_taken = (id_regT != 16'd0);
      JC_JUMP, JC_DB: w_taken = 1'b1;
      default:        w_taken = 1'b0;
    endcase
  end

  assign w_target = (jumpControl == JC_JUMP) ? id_operandX
                                             : id_pc + 16'd1 + id_offset;
  // A stall wins; the transfer is simply re-evaluated next cycle.
  assign w_accept = w_taken & ~stall;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_BOOT;
    else      r_state <= w_next_state;
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_BOOT:  w_next_state = S_FETCH;
      // Redirecting with a read in flight: the bus still owes us that word,
      // so keep its address stable and swallow the data in DROP.
      S_FETCH: if (w_accept && imem_req && !imem_ready) w_next_state = S_DROP;
      // mem_busy preempts the stale read; treat it as finished.
      S_DROP:  if (mem_busy || imem_ready) w_next_state = S_FETCH;
      default: w_next_state = S_BOOT;
    endcase
  end

  // Output logic
  always_comb begin
    imem_req  = 1'b0;
    imem_addr = r_pc;
    case (r_state)
      S_FETCH: imem_req = ~mem_busy;
      S_DROP: begin
        imem_req  = ~mem_busy;
        imem_addr = r_drop_addr;
      end
      default: imem_req = 1'b0;
    endcase
  end

  // Datapath: PC, instruction/PC to decoder, redirect pulse, stale address.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pc        <= RESET_PC;
      r_instr     <= NOP_INSTR;
      r_if_pc     <= 16'd0;
      r_redirect  <= 1'b0;
      r_drop_addr <= 16'd0;
    end else begin
      r_redirect <= w_accept;
      if (r_state == S_FETCH && w_next_state == S_DROP)
        r_drop_addr <= r_pc;
      if (w_accept) begin
        r_pc    <= w_target;
        r_instr <= NOP_INSTR;
      end else if (r_state == S_FETCH && !stall) begin
        if (!mem_busy && imem_ready) begin
          r_instr <= imem_rdata;
          r_if_pc <= r_pc;
          r_pc    <= r_pc + 16'd1;
        end else begin
          r_instr <= NOP_INSTR;   // bubble, PC held so nothing is skipped
        end
      end
    end
  end

  assign instruction = r_instr;
  assign if_pc       = r_if_pc;
  assign redirect    = r_redirect;

endmodule

// File: tb/tb_fetch_pc_unit.sv
module tb_fetch_pc_unit;

  localparam logic [15:0] NOP = 16'h0800;

  logic        clk, rst, stall, mem_busy, imem_ready;
  logic [2:0]  jumpControl;
  logic [15:0] id_pc, id_operandX, id_regT, id_offset;
  logic        imem_req, redirect;
  logic [15:0] imem_addr, imem_rdata, instruction, if_pc;

  int n_checks = 0;
  int n_pass   = 0;

  fetch_pc_unit dut (
    .clk(clk), .rst(rst), .stall(stall), .mem_busy(mem_busy),
    .jumpControl(jumpControl), .id_pc(id_pc), .id_operandX(id_operandX),
    .id_regT(id_regT), .id_offset(id_offset),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .imem_ready(imem_ready),
    .instruction(instruction), .if_pc(if_pc), .redirect(redirect)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory image: word at address a is 16'h4000 + a; garbage when not ready.
  function automatic logic [15:0] memfn(input logic [15:0] a);
    return 16'h4000 + a;
  endfunction
  assign imem_rdata = imem_ready ? memfn(imem_addr) : 16'hDEAD;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  typedef enum {M_BOOT, M_FETCH, M_DROP} mmode_t;
  mmode_t      m_mode;
  logic [15:0] m_pc, m_instr, m_ifpc, m_stale;
  logic        m_redir;

  function automatic bit taken_of(input logic [2:0] jc, input logic [15:0] x, input logic [15:0] t);
    case (jc)
      3'd1: return x == 0;
      3'd2: return x != 0;
      3'd3: return t == 0;
      3'd4: return t != 0;
      3'd5, 3'd6: return 1;
      default: return 0;
    endcase
  endfunction

  task automatic m_reset();
    m_mode = M_BOOT; m_pc = 16'h0000; m_instr = NOP; m_ifpc = 16'h0000;
    m_stale = 16'h0000; m_redir = 1'b0;
  endtask

  task automatic m_step();
    bit acc;
    logic [15:0] tgt;
    acc = taken_of(jumpControl, id_operandX, id_regT) && !stall;
    tgt = (jumpControl == 3'd5) ? id_operandX : 16'(id_pc + 16'd1 + id_offset);
    m_redir = acc;
    case (m_mode)
      M_BOOT: begin
        m_mode = M_FETCH;
        if (acc) begin m_pc = tgt; m_instr = NOP; end
      end
      M_FETCH: begin
        if (acc) begin
          if (!mem_busy && !imem_ready) begin m_mode = M_DROP; m_stale = m_pc; end
          m_pc = tgt; m_instr = NOP;
        end else if (!stall) begin
          if (!mem_busy && imem_ready) begin
            m_instr = memfn(m_pc); m_ifpc = m_pc; m_pc = m_pc + 16'd1;
          end else m_instr = NOP;
        end
      end
      default: begin
        if (acc) begin m_pc = tgt; m_instr = NOP; end
        if (mem_busy || imem_ready) m_mode = M_FETCH;
      end
    endcase
  endtask

  // Compare process: outputs checked every cycle on the falling edge.
  always @(negedge clk) begin
    bit exp_req;
    if (!rst) m_reset();
    exp_req = (m_mode != M_BOOT) && !mem_busy;
    check("m_instruction", instruction, m_instr);
    check("m_if_pc", if_pc, m_ifpc);
    check("m_redirect", {15'd0, redirect}, {15'd0, m_redir});
    check("m_imem_req", {15'd0, imem_req}, {15'd0, exp_req});
    if (exp_req) check("m_imem_addr", imem_addr, (m_mode == M_DROP) ? m_stale : m_pc);
    if (rst) m_step();
  end

  task automatic cyc();
    @(posedge clk); #2;
  endtask

  task automatic idle_in();
    jumpControl = 3'd0;
  endtask

  initial begin
    rst = 1'b1; stall = 0; mem_busy = 0; imem_ready = 1; jumpControl = 0;
    id_pc = 0; id_operandX = 16'h0001; id_regT = 0; id_offset = 0;
    #1 rst = 1'b0;
    cyc(); cyc();
    check("reset_instr", instruction, NOP);
    check("reset_ifpc", if_pc, 16'h0000);
    check("reset_redirect", {15'd0, redirect}, 16'd0);
    check("reset_req", {15'd0, imem_req}, 16'd0);
    rst = 1'b1;
    cyc();                                   // BOOT -> FETCH
    check("boot_instr", instruction, NOP);
    check("fetch0_addr", imem_addr, 16'h0000);
    cyc(); check("seq0_instr", instruction, 16'h4000); check("seq0_pc", if_pc, 16'h0000);
    cyc(); check("seq1_instr", instruction, 16'h4001); check("seq1_pc", if_pc, 16'h0001);
    cyc(); check("seq2_instr", instruction, 16'h4002); check("seq2_pc", if_pc, 16'h0002);

    // EQZ taken: 0x10 + 1 - 4 = 0x0D
    jumpControl = 3'd1; id_operandX = 0; id_pc = 16'h0010; id_offset = 16'hFFFC;
    cyc(); idle_in();
    check("eqz_redirect", {15'd0, redirect}, 16'd1);
    check("eqz_bubble", instruction, NOP);
    #1 check("eqz_target", imem_addr, 16'h000D);
    cyc(); check("eqz_fetch", instruction, 16'h400D); check("eqz_ifpc", if_pc, 16'h000D);
    // EQZ not taken
    jumpControl = 3'd1; id_operandX = 16'h0005;
    cyc(); idle_in();
    check("eqz_nt_redirect", {15'd0, redirect}, 16'd0);
    check("eqz_nt_instr", instruction, 16'h400E);

    // JUMP with read outstanding -> DROP on stale address 0x000F
    imem_ready = 0; jumpControl = 3'd5; id_operandX = 16'h1234;
    cyc(); idle_in();
    check("drop_redirect", {15'd0, redirect}, 16'd1);
    check("drop_addr0", imem_addr, 16'h000F);
    cyc(); check("drop_addr1", imem_addr, 16'h000F); check("drop_req", {15'd0, imem_req}, 16'd1);
    cyc(); check("drop_addr2", imem_addr, 16'h000F); check("drop_instr", instruction, NOP);
    imem_ready = 1;
    cyc(); check("drop_discard", instruction, NOP); check("drop_target", imem_addr, 16'h1234);
    cyc(); check("jump_fetch", instruction, 16'h5234); check("jump_ifpc", if_pc, 16'h1234);

    // Stall over a taken TNEZ: held, then redirect once released
    stall = 1; jumpControl = 3'd4; id_regT = 16'h0001; id_pc = 16'h0100; id_offset = 16'h0005;
    cyc(); check("stall_hold0", instruction, 16'h5234); check("stall_nored0", {15'd0, redirect}, 16'd0);
    cyc(); check("stall_hold1", instruction, 16'h5234); check("stall_nored1", {15'd0, redirect}, 16'd0);
    stall = 0;
    cyc(); idle_in();
    check("stall_redirect", {15'd0, redirect}, 16'd1);
    #1 check("tnez_target", imem_addr, 16'h0106);

    // mem_busy bubble at 0x0020, no skip
    jumpControl = 3'd5; id_operandX = 16'h0020;
    cyc(); idle_in();
    mem_busy = 1;
    #1 check("busy_req", {15'd0, imem_req}, 16'd0);
    cyc(); check("busy_bubble", instruction, NOP);
    mem_busy = 0;
    cyc(); check("busy_fetch", instruction, 16'h4020); check("busy_ifpc", if_pc, 16'h0020);

    // PC wrap at 0xFFFF
    jumpControl = 3'd5; id_operandX = 16'hFFFF;
    cyc(); idle_in();
    cyc(); check("wrap_instr", instruction, 16'h3FFF); check("wrap_addr", imem_addr, 16'h0000);
    cyc(); check("wrap_next", instruction, 16'h4000); check("wrap_ifpc", if_pc, 16'h0000);

    // Reset during a wait
    imem_ready = 0;
    cyc();
    rst = 0;
    #1 check("mid_rst_instr", instruction, NOP);
    check("mid_rst_ifpc", if_pc, 16'h0000);
    check("mid_rst_req", {15'd0, imem_req}, 16'd0);
    cyc(); rst = 1; imem_ready = 1;
    #1 check("rel_boot_req", {15'd0, imem_req}, 16'd0);
    cyc(); check("rel_fetch_req", {15'd0, imem_req}, 16'd1); check("rel_fetch_addr", imem_addr, 16'h0000);

    // Randomised traffic, checked by the model every cycle
    for (int i = 0; i < 600; i++) begin
      rst         = ($urandom_range(0, 149) != 0);
      stall       = ($urandom_range(0, 4) == 0);
      mem_busy    = ($urandom_range(0, 5) == 0);
      imem_ready  = ($urandom_range(0, 2) != 0);
      jumpControl = ($urandom_range(0, 2) == 0) ? 3'($urandom_range(0, 7)) : 3'd0;
      id_pc       = 16'($urandom);
      id_offset   = 16'($urandom_range(0, 1) == 0 ? $urandom_range(0, 15) : 16'hFFF0 + $urandom_range(0, 15));
      id_operandX = ($urandom_range(0, 2) == 0) ? 16'h0000 : 16'($urandom);
      id_regT     = ($urandom_range(0, 1) == 0) ? 16'h0000 : 16'($urandom);
      cyc();
    end
    rst = 1; cyc(); cyc();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
